// File: rtl/uart_result_tx_pkg.sv
// Shared types and constants for the result-frame UART transmitter.
package uart_result_tx_pkg;

    typedef enum logic [3:0] {
        RTX_IDLE,
        RTX_HDR,
        RTX_LEN,
        RTX_CMD,
        RTX_POP,
        RTX_CAP,
        RTX_DATA,
        RTX_TRL,
        RTX_FIN
    } rtx_state_t;

    localparam logic [7:0]  FRAME_HEADER       = 8'hFE;
    localparam logic [7:0]  FRAME_TRAILER      = 8'hEF;
    localparam logic [7:0]  DEFAULT_RESULT_CMD = 8'h05;
    localparam int unsigned DEFAULT_MAX_N      = 16;

    typedef struct packed {
        logic       load;
        logic [7:0] data;
        logic       busy;
        logic       byte_done;
    } ser_hs_t;

    // LEN counts the CMD byte plus the data bytes.
    function automatic logic [7:0] frame_len(input logic [3:0] n);
        return 8'(n) + 8'd1;
    endfunction

endpackage

// File: rtl/uart_result_tx_if.sv
// Control, FIFO-read and serial-line signals of uart_result_tx.
interface uart_result_tx_if;
    logic       start;
    logic [3:0] n;
    logic [7:0] fifo_data;
    logic       fifo_empty;
    logic       fifo_pop;
    logic       Tx_out;
    logic       busy;
    logic       done;

    modport master (
        output start, n, fifo_data, fifo_empty,
        input  fifo_pop, Tx_out, busy, done
    );

    modport slave (
        input  start, n, fifo_data, fifo_empty,
        output fifo_pop, Tx_out, busy, done
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// Byte serializer: start bit, d[0]..d[7], optional even parity, stop bit.
// UART_RESULT_TX_PARITY_EN adds the parity bit (11 bit-times per byte).
module uart_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       Tx_out,
    output logic       busy,
    output logic       byte_done
);
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
`ifdef UART_RESULT_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_idx;
    logic [9:0]       shreg;
    logic             bit_end;

    assign bit_end   = busy && (baud_cnt == CNT_LAST);
    // Combinational so the frame FSM can advance on the last stop-bit cycle.
    assign byte_done = bit_end && (bit_idx == BIT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Tx_out   <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '1;
        end else if (!busy) begin
            if (load) begin
                Tx_out   <= 1'b0;
                busy     <= 1'b1;
                baud_cnt <= '0;
                bit_idx  <= '0;
`ifdef UART_RESULT_TX_PARITY_EN
                shreg    <= {1'b1, ^data, data};
`else
                shreg    <= {2'b11, data};
`endif
            end
        end else if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == BIT_LAST) begin
                busy    <= 1'b0;
                bit_idx <= '0;
                Tx_out  <= 1'b1;
            end else begin
                bit_idx <= bit_idx + 4'd1;
                Tx_out  <= shreg[0];
                shreg   <= {1'b1, shreg[9:1]};
            end
        end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/uart_result_tx.sv
// Result-frame transmitter: FE, LEN, CMD, n FIFO bytes, EF, sent as 8N1.
// UART_RESULT_TX_PARITY_EN (in the serializer) adds even parity per byte.
module uart_result_tx
    import uart_result_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  RESULT_CMD   = DEFAULT_RESULT_CMD,
    parameter int unsigned MAX_N        = DEFAULT_MAX_N
) (
    input logic             clk,
    input logic             reset,
    uart_result_tx_if.slave bus
);
    rtx_state_t state, byte_next;
    logic [3:0] n_reg, data_cnt;
    logic [7:0] byte_reg, frame_byte, load_data;
    logic       load_r, sent, busy_r, done_r, accept;
    logic       ser_busy, ser_byte_done, tx;
    ser_hs_t    ser;

    assign ser = '{load: load_r, data: load_data, busy: ser_busy, byte_done: ser_byte_done};

    assign accept       = bus.start && (bus.n != '0) && (32'(bus.n) <= MAX_N);
    // Pop is decoded from state so fifo_data is ready for capture in CAP.
    assign bus.fifo_pop = (state == RTX_POP) && !bus.fifo_empty;
    assign bus.Tx_out   = tx;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;

    always_comb begin
        frame_byte = FRAME_HEADER;
        case (state)
            RTX_LEN:  frame_byte = frame_len(n_reg);
            RTX_CMD:  frame_byte = RESULT_CMD;
            RTX_DATA: frame_byte = byte_reg;
            RTX_TRL:  frame_byte = FRAME_TRAILER;
            default:  ;
        endcase
    end

    always_comb begin
        byte_next = RTX_IDLE;
        case (state)
            RTX_HDR:  byte_next = RTX_LEN;
            RTX_LEN:  byte_next = RTX_CMD;
            RTX_CMD:  byte_next = RTX_POP;
            RTX_DATA: byte_next = (data_cnt < n_reg) ? RTX_POP : RTX_TRL;
            RTX_TRL:  byte_next = RTX_FIN;
            default:  byte_next = RTX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RTX_IDLE;
            n_reg     <= '0;
            data_cnt  <= '0;
            byte_reg  <= '0;
            load_r    <= 1'b0;
            load_data <= '0;
            sent      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            load_r <= 1'b0;
            done_r <= 1'b0;
            case (state)
                RTX_IDLE: begin
                    if (accept) begin
                        n_reg    <= bus.n;
                        data_cnt <= '0;
                        busy_r   <= 1'b1;
                        state    <= RTX_HDR;
                    end
                end
                RTX_HDR, RTX_LEN, RTX_CMD, RTX_DATA, RTX_TRL: begin
                    if (sent && ser.byte_done) begin
                        sent  <= 1'b0;
                        state <= byte_next;
                        if (state == RTX_TRL) done_r <= 1'b1;
                    end else if (!sent && !ser.busy) begin
                        load_r    <= 1'b1;
                        load_data <= frame_byte;
                        sent      <= 1'b1;
                    end
                end
                RTX_POP: begin
                    if (!bus.fifo_empty) state <= RTX_CAP;
                end
                RTX_CAP: begin
                    byte_reg <= bus.fifo_data;
                    data_cnt <= data_cnt + 4'd1;
                    state    <= RTX_DATA;
                end
                RTX_FIN: begin
                    busy_r <= 1'b0;
                    state  <= RTX_IDLE;
                end
                default: state <= RTX_IDLE;
            endcase
        end
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clk      (clk),
        .reset    (reset),
        .load     (ser.load),
        .data     (ser.data),
        .Tx_out   (tx),
        .busy     (ser_busy),
        .byte_done(ser_byte_done)
    );
endmodule

// File: tb/tb_uart_result_tx.sv
// Directed bench for uart_result_tx with CLKS_PER_BIT=4 and a small FIFO model.
module tb_uart_result_tx;
    localparam int unsigned CPB = 4;
`ifdef UART_RESULT_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    logic clk = 1'b0;
    logic reset;
    uart_result_tx_if bus();

    uart_result_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // FIFO model: data appears the cycle after a pop.
    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr = '0;
    logic [7:0] rd_ptr = '0;
    assign bus.fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (bus.fifo_pop && (wr_ptr != rd_ptr)) begin
            bus.fifo_data <= mem[rd_ptr];
            rd_ptr        <= rd_ptr + 8'd1;
        end
    end

    int unsigned pop_cnt = 0, done_cnt = 0, low_cnt = 0;
    always @(negedge clk) begin
        if (bus.fifo_pop === 1'b1) pop_cnt  <= pop_cnt + 1;
        if (bus.done === 1'b1)     done_cnt <= done_cnt + 1;
        if (bus.Tx_out !== 1'b1)   low_cnt  <= low_cnt + 1;
    end

    int unsigned n_checks = 0, n_pass = 0;
    int unsigned base_pop, base_done, base_low;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic send_start(input logic [3:0] nv);
        bus.n     = nv;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic rx_byte(output logic [7:0] b, output int unsigned waited, output logic shape_ok);
        logic [10:0] bits;
        logic s;
        waited = 0;
        shape_ok = 1'b1;
        bits = '0;
        while (bus.Tx_out !== 1'b0 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        for (int i = 0; i < FRAME_BITS; i++) begin
            for (int j = 0; j < CPB; j++) begin
                s = bus.Tx_out;
                if (j == 0) bits[i] = s;
                else if (s !== bits[i]) shape_ok = 1'b0;
                @(negedge clk);
            end
        end
        b = bits[8:1];
        if (bits[0] !== 1'b0 || bits[FRAME_BITS-1] !== 1'b1) shape_ok = 1'b0;
`ifdef UART_RESULT_TX_PARITY_EN
        if (bits[9] !== ^bits[8:1]) shape_ok = 1'b0;
`endif
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp_b, input int unsigned exp_gap);
        logic [7:0] b;
        int unsigned w;
        logic ok;
        rx_byte(b, w, ok);
        check({tag, "_data"}, b, exp_b);
        check({tag, "_gap"}, w, exp_gap);
        check({tag, "_shape"}, ok, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.n     = '0;
        #1 reset  = 1'b0;

        // Reset and idle line
        repeat (3) @(negedge clk);
        check("rst_tx", bus.Tx_out, 1'b1);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_pop", bus.fifo_pop, 1'b0);
        reset = 1'b1;
        base_low = low_cnt;
        repeat (20) @(negedge clk);
        check("idle_tx_low", low_cnt - base_low, 0);
        check("idle_busy", bus.busy, 1'b0);
        check("idle_done", bus.done, 1'b0);

        // Basic frame, n=3
        push(8'h11); push(8'h22); push(8'h33);
        base_pop = pop_cnt; base_done = done_cnt;
        send_start(4'd3);
        check("b_busy_rise", bus.busy, 1'b1);
        check("b_tx_still_high", bus.Tx_out, 1'b1);
        expect_byte("b_hdr", 8'hFE, 2);
        expect_byte("b_len", 8'h04, 2);
        expect_byte("b_cmd", 8'h05, 2);
        expect_byte("b_d0", 8'h11, 4);
        expect_byte("b_d1", 8'h22, 4);
        expect_byte("b_d2", 8'h33, 4);
        expect_byte("b_trl", 8'hEF, 2);
        check("b_done_pulse", bus.done, 1'b1);
        check("b_busy_fin", bus.busy, 1'b1);
        @(negedge clk);
        check("b_done_low", bus.done, 1'b0);
        check("b_busy_low", bus.busy, 1'b0);
        check("b_pop_count", pop_cnt - base_pop, 3);
        check("b_done_count", done_cnt - base_done, 1);

        // start with n=0 is ignored
        base_low = low_cnt; base_done = done_cnt;
        send_start(4'd0);
        check("n0_busy", bus.busy, 1'b0);
        repeat (30) @(negedge clk);
        check("n0_tx_low", low_cnt - base_low, 0);
        check("n0_done", done_cnt - base_done, 0);
        check("n0_busy_end", bus.busy, 1'b0);

        // Empty-FIFO stall with an ignored mid-frame start
        push(8'hA5);
        base_pop = pop_cnt; base_done = done_cnt;
        send_start(4'd2);
        expect_byte("s_hdr", 8'hFE, 2);
        expect_byte("s_len", 8'h03, 2);
        expect_byte("s_cmd", 8'h05, 2);
        expect_byte("s_d0", 8'hA5, 4);
        base_low = low_cnt;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 20) begin bus.n = 4'd5; bus.start = 1'b1; end
            if (i == 21) bus.start = 1'b0;
        end
        check("s_stall_tx_low", low_cnt - base_low, 0);
        check("s_stall_pops", pop_cnt - base_pop, 1);
        check("s_stall_busy", bus.busy, 1'b1);
        push(8'h5A);
        expect_byte("s_d1", 8'h5A, 4);
        expect_byte("s_trl", 8'hEF, 2);
        check("s_done_pulse", bus.done, 1'b1);
        @(negedge clk);
        check("s_busy_low", bus.busy, 1'b0);
        base_low = low_cnt;
        repeat (60) @(negedge clk);
        check("s_no_second_frame", low_cnt - base_low, 0);
        check("s_busy_after", bus.busy, 1'b0);
        check("s_pop_count", pop_cnt - base_pop, 2);
        check("s_done_count", done_cnt - base_done, 1);

        // Asynchronous reset during CMD data bits
        push(8'h7E);
        send_start(4'd1);
        expect_byte("r_hdr", 8'hFE, 2);
        expect_byte("r_len", 8'h02, 2);
        repeat (2) @(negedge clk);
        check("r_cmd_start", bus.Tx_out, 1'b0);
        repeat (6) @(negedge clk);
        check("r_cmd_d0", bus.Tx_out, 1'b1);
        repeat (3) @(negedge clk);
        check("r_cmd_d1", bus.Tx_out, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("r_async_tx", bus.Tx_out, 1'b1);
        check("r_async_busy", bus.busy, 1'b0);
        check("r_async_done", bus.done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        base_pop = pop_cnt; base_done = done_cnt;
        send_start(4'd1);
        expect_byte("r2_hdr", 8'hFE, 2);
        expect_byte("r2_len", 8'h02, 2);
        expect_byte("r2_cmd", 8'h05, 2);
        expect_byte("r2_d0", 8'h7E, 4);
        expect_byte("r2_trl", 8'hEF, 2);
        check("r2_done_pulse", bus.done, 1'b1);
        @(negedge clk);
        check("r2_busy_low", bus.busy, 1'b0);
        check("r2_pop_count", pop_cnt - base_pop, 1);
        check("r2_done_count", done_cnt - base_done, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
